// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    RUN,
    DELAY,
    HALTED
  } fetch_state_t;

  localparam addr_t RESET_VECTOR = 32'hBFC0_0000;
  localparam addr_t HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_instr_fetch_if.sv
// Harvard instruction-memory port: the fetch stage drives the address and
// the memory returns the instruction word for that address.
interface mips_instr_fetch_if;
  import mips_pkg::*;

  addr_t       instr_address;
  logic [31:0] instr_readdata;

  modport master (
    output instr_address,
    input  instr_readdata
  );

  modport slave (
    input  instr_address,
    output instr_readdata
  );

endinterface

// File: rtl/mips_instr_fetch.sv
// Instruction fetch stage: owns the PC, sequences the branch delay slot and
// stops the CPU when execution reaches the halt address or a misaligned
// branch target is accepted.
module mips_instr_fetch #(
  parameter mips_pkg::addr_t RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter mips_pkg::addr_t HALT_ADDR    = mips_pkg::HALT_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  mips_instr_fetch_if.master   mem,
  output logic [31:0]          instr_out,
  output logic                 instr_valid,
  output logic [31:0]          link_addr,
  output logic                 in_delay_slot,
  output logic                 active,
  output logic                 addr_error
);
  import mips_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;
  addr_t        pc;
  addr_t        pc_next;
  addr_t        pc_plus4;
  addr_t        target;
  addr_t        target_next;
  logic         active_next;
  logic         addr_error_next;

  assign mem.instr_address = pc;
  assign instr_out         = mem.instr_readdata;
  assign instr_valid       = active && !stall && clk_enable;
  assign link_addr         = pc + 32'd8;
  assign in_delay_slot     = (state == DELAY);
  assign pc_plus4          = pc + 32'd4;

  // Next-PC selection and state transitions; the first branch seen in RUN
  // wins, and anything arriving while its delay slot is fetched is ignored.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    target_next     = target;
    active_next     = active;
    addr_error_next = addr_error;
    case (state)
      RUN: begin
        if (!stall) begin
          if (branch_taken) begin
            if (branch_target[1:0] != 2'b00) begin
              addr_error_next = 1'b1;
              active_next     = 1'b0;
              state_next      = HALTED;
            end else begin
              target_next = branch_target;
              pc_next     = pc_plus4;
              state_next  = DELAY;
            end
          end else begin
            pc_next = pc_plus4;
            if (pc_plus4 == HALT_ADDR) begin
              active_next = 1'b0;
              state_next  = HALTED;
            end
          end
        end
      end
      DELAY: begin
        if (!stall) begin
          pc_next = target;
          if (target == HALT_ADDR) begin
            active_next = 1'b0;
            state_next  = HALTED;
          end else begin
            state_next = RUN;
          end
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        active_next = 1'b0;
        state_next  = HALTED;
      end
    endcase
  end

  // State, PC and flag registers; everything freezes while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      target     <= '0;
      active     <= 1'b1;
      addr_error <= 1'b0;
    end else if (clk_enable) begin
      state      <= state_next;
      pc         <= pc_next;
      target     <= target_next;
      active     <= active_next;
      addr_error <= addr_error_next;
    end
  end

endmodule
